// File: rtl/blind_rotate_sequencer_if.sv
// Control bundle between the blind-rotation sequencer and the units it schedules
// (INTT, NTT bank, key MAC). The sequencer side uses the master modport.
interface blind_rotate_sequencer_if #(
    parameter int NTT_NUMBER = 4,
    parameter int XFER_W     = 7,
    parameter int KEY_W      = 9
);
    logic                  start;
    logic                  intt_done;
    logic [NTT_NUMBER-1:0] ntt_done;
    logic                  intt_start;
    logic                  xfer_en;
    logic [XFER_W-1:0]     xfer_cnt;
    logic                  ntt_start;
    logic                  mac_en;
    logic [KEY_W-1:0]      key_idx;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        input  start, intt_done, ntt_done,
        output intt_start, xfer_en, xfer_cnt, ntt_start, mac_en, key_idx, busy, done, error
    );

    modport slave (
        output start, intt_done, ntt_done,
        input  intt_start, xfer_en, xfer_cnt, ntt_start, mac_en, key_idx, busy, done, error
    );
endinterface

// File: rtl/blind_rotate_sequencer.sv
// Scheduler for the blind-rotation accumulator loop:
// INTT -> reverse/decompose stream -> parallel NTTs -> key MAC, repeated NUM_ITER times.
// Every output is a register decoded from the next state, so each output lines up
// with the cycle in which the FSM occupies the corresponding state.
module blind_rotate_sequencer #(
    parameter int RING_SIZE   = 1024,
    parameter int PE_DEPTH    = 3,
    parameter int STAGE_DELAY = 8,
    parameter int NTT_NUMBER  = 4,
    parameter int NUM_ITER    = 500,
    parameter int TIMEOUT     = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    blind_rotate_sequencer_if.master bus
);
    localparam int WIN    = (RING_SIZE >> (PE_DEPTH + 1)) + STAGE_DELAY;
    localparam int XFER_W = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int KEY_W  = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INTT_GO,
        S_INTT_WAIT,
        S_XFER,
        S_NTT_GO,
        S_NTT_WAIT,
        S_MAC,
        S_DONE
    } state_t;

    state_t                state_reg, state_next;
    logic [XFER_W-1:0]     win_cnt_reg, win_cnt_next;
    logic [WAIT_W-1:0]     wait_cnt_reg, wait_cnt_next;
    logic [KEY_W-1:0]      key_idx_reg, key_idx_next;
    logic                  error_reg, error_next;
    logic [NTT_NUMBER-1:0] sticky_reg, sticky_next;
    logic [NTT_NUMBER-1:0] sticky_or;
    logic                  all_done;
    logic                  timeout_hit;
    logic                  win_last;

    logic                  intt_start_reg;
    logic                  xfer_en_reg;
    logic [XFER_W-1:0]     xfer_cnt_reg;
    logic                  ntt_start_reg;
    logic                  mac_en_reg;
    logic                  busy_reg;
    logic                  done_reg;

    // Per-unit completion seen so far, including a flag arriving this very cycle.
    for (genvar gi = 0; gi < NTT_NUMBER; gi++) begin : g_sticky
        assign sticky_or[gi] = sticky_reg[gi] | bus.ntt_done[gi];
    end

    assign all_done    = &sticky_or;
    assign timeout_hit = (wait_cnt_reg == WAIT_W'(TIMEOUT - 1));
    assign win_last    = (win_cnt_reg == XFER_W'(WIN - 1));

    // Next-state, counter and flag logic; counters default to zero so every window
    // and every wait starts counting from zero on entry.
    always_comb begin
        state_next    = state_reg;
        win_cnt_next  = '0;
        wait_cnt_next = '0;
        key_idx_next  = key_idx_reg;
        error_next    = error_reg;
        sticky_next   = sticky_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    state_next   = S_INTT_GO;
                    error_next   = 1'b0;
                    key_idx_next = '0;
                end
            end
            S_INTT_GO: begin
                state_next = S_INTT_WAIT;
            end
            S_INTT_WAIT: begin
                if (bus.intt_done) begin
                    state_next = S_XFER;
                end else if (timeout_hit) begin
                    state_next = S_IDLE;
                    error_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            S_XFER: begin
                if (win_last) begin
                    state_next = S_NTT_GO;
                end else begin
                    win_cnt_next = win_cnt_reg + 1'b1;
                end
            end
            S_NTT_GO: begin
                // Flags present now belong to the previous round and are dropped.
                sticky_next = '0;
                state_next  = S_NTT_WAIT;
            end
            S_NTT_WAIT: begin
                sticky_next = sticky_or;
                if (all_done) begin
                    state_next = S_MAC;
                end else if (timeout_hit) begin
                    state_next = S_IDLE;
                    error_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            S_MAC: begin
                if (win_last) begin
                    if (key_idx_reg == KEY_W'(NUM_ITER - 1)) begin
                        state_next = S_DONE;
                    end else begin
                        key_idx_next = key_idx_reg + 1'b1;
                        state_next   = S_INTT_GO;
                    end
                end else begin
                    win_cnt_next = win_cnt_reg + 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            win_cnt_reg    <= '0;
            wait_cnt_reg   <= '0;
            key_idx_reg    <= '0;
            error_reg      <= 1'b0;
            sticky_reg     <= '0;
            intt_start_reg <= 1'b0;
            xfer_en_reg    <= 1'b0;
            xfer_cnt_reg   <= '0;
            ntt_start_reg  <= 1'b0;
            mac_en_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            win_cnt_reg    <= win_cnt_next;
            wait_cnt_reg   <= wait_cnt_next;
            key_idx_reg    <= key_idx_next;
            error_reg      <= error_next;
            sticky_reg     <= sticky_next;
            intt_start_reg <= (state_next == S_INTT_GO);
            xfer_en_reg    <= (state_next == S_XFER);
            xfer_cnt_reg   <= (state_next == S_XFER) ? win_cnt_next : '0;
            ntt_start_reg  <= (state_next == S_NTT_GO);
            mac_en_reg     <= (state_next == S_MAC);
            busy_reg       <= (state_next != S_IDLE);
            done_reg       <= (state_next == S_DONE);
        end
    end

    assign bus.intt_start = intt_start_reg;
    assign bus.xfer_en    = xfer_en_reg;
    assign bus.xfer_cnt   = xfer_cnt_reg;
    assign bus.ntt_start  = ntt_start_reg;
    assign bus.mac_en     = mac_en_reg;
    assign bus.key_idx    = key_idx_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.error      = error_reg;
endmodule

// File: tb/tb_blind_rotate_sequencer.sv
// Bench for blind_rotate_sequencer. A reactive environment answers intt_start/ntt_start
// with done flags; the expected output traces are built from the run timeline
// (iteration period = intt delay + window + NTT latency + window) and compared cycle by cycle.
module tb_blind_rotate_sequencer;
    localparam int WIN      = 72;
    localparam int NUM_ITER = 2;
    localparam int TIMEOUT  = 100;
    localparam int NTT_N    = 4;
    localparam int NSIG     = 9;
    localparam int MAXC     = 700;

    logic clk;
    logic reset;

    blind_rotate_sequencer_if #(.NTT_NUMBER(NTT_N), .XFER_W(7), .KEY_W(1)) bus ();

    blind_rotate_sequencer #(
        .RING_SIZE(1024), .PE_DEPTH(3), .STAGE_DELAY(8),
        .NTT_NUMBER(NTT_N), .NUM_ITER(NUM_ITER), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests_run;
    int tests_failed;

    // Traces: 0 intt_start, 1 xfer_en, 2 xfer_cnt, 3 ntt_start, 4 mac_en,
    //         5 key_idx, 6 busy, 7 done, 8 error
    int act_tr[NSIG][MAXC];
    int exp_tr[NSIG][MAXC];
    bit start_plan[MAXC];
    bit reset_plan[MAXC];
    int ntt_off[NTT_N];

    function automatic string sig_name(input int s);
        case (s)
            0: return "intt_start";
            1: return "xfer_en";
            2: return "xfer_cnt";
            3: return "ntt_start";
            4: return "mac_en";
            5: return "key_idx";
            6: return "busy";
            7: return "done";
            default: return "error";
        endcase
    endfunction

    function automatic void put(input int s, input int k, input int v);
        if (k >= 0 && k < MAXC) exp_tr[s][k] = v;
    endfunction

    function automatic void clear_expect();
        for (int k = 0; k < MAXC; k++)
            for (int s = 0; s < NSIG; s++) exp_tr[s][k] = 0;
    endfunction

    function automatic void clear_plans();
        for (int k = 0; k < MAXC; k++) begin
            start_plan[k] = 1'b0;
            reset_plan[k] = 1'b0;
        end
    endfunction

    // A reset seen at cycle r leaves every output at its reset value from r+1 on.
    function automatic void truncate(input int r);
        for (int k = r + 1; k < MAXC; k++)
            for (int s = 0; s < NSIG; s++) exp_tr[s][k] = 0;
    endfunction

    // Expected timeline of a run whose start is presented in cycle s0.
    function automatic void model_run(input int s0, input int dly, input bit withheld, input int lat);
        int t;
        int x;
        int n;
        int m;
        truncate(s0);
        t = s0 + 1;
        for (int it = 0; it < NUM_ITER; it++) begin
            put(0, t, 1);
            for (int k = t; k < MAXC; k++) put(5, k, it);
            if (withheld) begin
                for (int k = t; k <= t + TIMEOUT; k++) put(6, k, 1);
                for (int k = t + TIMEOUT + 1; k < MAXC; k++) put(8, k, 1);
                return;
            end
            x = t + dly + 1;
            for (int j = 0; j < WIN; j++) begin
                put(1, x + j, 1);
                put(2, x + j, j);
            end
            n = x + WIN;
            put(3, n, 1);
            m = n + lat;
            for (int j = 0; j < WIN; j++) put(4, m + j, 1);
            for (int k = t; k < m + WIN; k++) put(6, k, 1);
            t = m + WIN;
        end
        put(6, t, 1);
        put(7, t, 1);
    endfunction

    // First cycle where the trace disagrees; xfer_cnt only matters inside the window.
    function automatic int first_diff(input int s, input int n);
        for (int k = 0; k < n; k++) begin
            if (!(s == 2 && exp_tr[1][k] == 0)) begin
                if (act_tr[s][k] != exp_tr[s][k]) return k;
            end
        end
        return -1;
    endfunction

    function automatic int first_high(input int s, input int n);
        for (int k = 0; k < n; k++)
            if (act_tr[s][k] != 0) return k;
        return -1;
    endfunction

    function automatic int count_high(input int s, input int n);
        int c;
        c = 0;
        for (int k = 0; k < n; k++)
            if (act_tr[s][k] != 0) c++;
        return c;
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.intt_done = 1'b0;
        bus.ntt_done = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Runs n cycles: records outputs on the falling edge, then drives the plans and
    // the environment's done responses for the next rising edge.
    task automatic simulate(input int n, input int dly, input bit withheld, input bit level);
        int intt_due;
        int ntt_due[NTT_N];
        intt_due = -1;
        for (int i = 0; i < NTT_N; i++) ntt_due[i] = -1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            act_tr[0][k] = int'(bus.intt_start);
            act_tr[1][k] = int'(bus.xfer_en);
            act_tr[2][k] = int'(bus.xfer_cnt);
            act_tr[3][k] = int'(bus.ntt_start);
            act_tr[4][k] = int'(bus.mac_en);
            act_tr[5][k] = int'(bus.key_idx);
            act_tr[6][k] = int'(bus.busy);
            act_tr[7][k] = int'(bus.done);
            act_tr[8][k] = int'(bus.error);
            if (bus.intt_start) intt_due = k + dly;
            if (bus.ntt_start)
                for (int i = 0; i < NTT_N; i++) ntt_due[i] = k + ntt_off[i];
            if (reset_plan[k]) begin
                intt_due = -1;
                for (int i = 0; i < NTT_N; i++) ntt_due[i] = -1;
            end
            reset = reset_plan[k];
            bus.start = start_plan[k];
            bus.intt_done = !withheld && (k == intt_due);
            for (int i = 0; i < NTT_N; i++) bus.ntt_done[i] = level || (k == ntt_due[i]);
        end
        reset = 1'b0;
        bus.start = 1'b0;
        bus.intt_done = 1'b0;
        bus.ntt_done = '0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        tests_run++;
        if ({bus.intt_start, bus.xfer_en, bus.ntt_start, bus.mac_en, bus.busy, bus.done, bus.error} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {bus.intt_start, bus.xfer_en, bus.ntt_start, bus.mac_en, bus.busy, bus.done, bus.error});
        end
        tests_run++;
        if (bus.key_idx !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_key_idx: got %0d expected 0", bus.key_idx);
        end
        tests_run++;
        if (bus.xfer_cnt !== 7'd0) begin
            tests_failed++;
            $display("FAIL reset_xfer_cnt: got %0d expected 0", bus.xfer_cnt);
        end
        $display("[TB] test_reset: outputs sampled after reset");
    endtask

    task automatic test_basic();
        int n;
        int dk;
        n = 380;
        apply_reset();
        clear_plans();
        clear_expect();
        for (int i = 0; i < NTT_N; i++) ntt_off[i] = 20;
        start_plan[0] = 1'b1;
        model_run(0, 10, 1'b0, 21);
        simulate(n, 10, 1'b0, 1'b0);
        for (int s = 0; s < NSIG; s++) begin
            dk = first_diff(s, n);
            tests_run++;
            if (dk != -1) begin
                tests_failed++;
                $display("FAIL basic_%s cycle %0d: got %0d expected %0d", sig_name(s), dk, act_tr[s][dk], exp_tr[s][dk]);
            end
        end
        tests_run++;
        if (count_high(0, n) != 2 || count_high(3, n) != 2 || count_high(7, n) != 1) begin
            tests_failed++;
            $display("FAIL basic_pulse_counts: got intt=%0d ntt=%0d done=%0d expected 2 2 1",
                     count_high(0, n), count_high(3, n), count_high(7, n));
        end
        tests_run++;
        if (count_high(1, n) != 2 * WIN || count_high(4, n) != 2 * WIN) begin
            tests_failed++;
            $display("FAIL basic_window_len: got xfer=%0d mac=%0d expected %0d each",
                     count_high(1, n), count_high(4, n), 2 * WIN);
        end
        $display("[TB] test_basic: intt_delay=10 ntt_delay=20 cycles=%0d", n);
    endtask

    task automatic test_staggered();
        int n;
        int dk;
        int mac_first;
        n = 350;
        apply_reset();
        clear_plans();
        clear_expect();
        ntt_off[0] = 5; ntt_off[1] = 7; ntt_off[2] = 9; ntt_off[3] = 12;
        start_plan[0] = 1'b1;
        model_run(0, 10, 1'b0, 13);
        simulate(n, 10, 1'b0, 1'b0);
        for (int s = 0; s < NSIG; s++) begin
            dk = first_diff(s, n);
            tests_run++;
            if (dk != -1) begin
                tests_failed++;
                $display("FAIL stagger_%s cycle %0d: got %0d expected %0d", sig_name(s), dk, act_tr[s][dk], exp_tr[s][dk]);
            end
        end
        // ntt_start lands in cycle 1 + 10 + 1 + WIN; the last flag comes 12 later.
        mac_first = first_high(4, n);
        tests_run++;
        if (mac_first != 1 + 10 + 1 + WIN + 13) begin
            tests_failed++;
            $display("FAIL stagger_mac_rise: got cycle %0d expected %0d", mac_first, 1 + 10 + 1 + WIN + 13);
        end
        $display("[TB] test_staggered: offsets 5/7/9/12 first mac_en cycle %0d", mac_first);
    endtask

    task automatic test_start_ignored();
        int n;
        int dk;
        n = 380;
        apply_reset();
        clear_plans();
        clear_expect();
        for (int i = 0; i < NTT_N; i++) ntt_off[i] = 20;
        start_plan[0] = 1'b1;
        start_plan[30] = 1'b1;    // inside the first xfer window
        start_plan[353] = 1'b1;   // the done cycle
        model_run(0, 10, 1'b0, 21);
        simulate(n, 10, 1'b0, 1'b0);
        for (int s = 0; s < NSIG; s++) begin
            dk = first_diff(s, n);
            tests_run++;
            if (dk != -1) begin
                tests_failed++;
                $display("FAIL busy_start_%s cycle %0d: got %0d expected %0d", sig_name(s), dk, act_tr[s][dk], exp_tr[s][dk]);
            end
        end
        tests_run++;
        if (count_high(0, n) != 2 || count_high(7, n) != 1) begin
            tests_failed++;
            $display("FAIL busy_start_counts: got intt=%0d done=%0d expected 2 1", count_high(0, n), count_high(7, n));
        end
        $display("[TB] test_start_ignored: starts at cycles 30 and 353 while busy");
    endtask

    task automatic test_timeout();
        int n;
        int dk;
        n = 130;
        apply_reset();
        clear_plans();
        clear_expect();
        for (int i = 0; i < NTT_N; i++) ntt_off[i] = 20;
        start_plan[0] = 1'b1;
        start_plan[110] = 1'b1;
        model_run(0, 10, 1'b1, 21);
        model_run(110, 10, 1'b1, 21);
        simulate(n, 10, 1'b1, 1'b0);
        for (int s = 0; s < NSIG; s++) begin
            dk = first_diff(s, n);
            tests_run++;
            if (dk != -1) begin
                tests_failed++;
                $display("FAIL timeout_%s cycle %0d: got %0d expected %0d", sig_name(s), dk, act_tr[s][dk], exp_tr[s][dk]);
            end
        end
        tests_run++;
        if (act_tr[8][2 + TIMEOUT] != 1 || act_tr[6][2 + TIMEOUT] != 0 || act_tr[8][111] != 0) begin
            tests_failed++;
            $display("FAIL timeout_error_flag: got error=%0d busy=%0d then error=%0d expected 1 0 0",
                     act_tr[8][2 + TIMEOUT], act_tr[6][2 + TIMEOUT], act_tr[8][111]);
        end
        $display("[TB] test_timeout: intt_done withheld, restart at cycle 110");
    endtask

    task automatic test_reset_mid_mac();
        int n;
        int dk;
        int r;
        n = 680;
        apply_reset();
        clear_plans();
        clear_expect();
        for (int i = 0; i < NTT_N; i++) ntt_off[i] = 20;
        // Second iteration's MAC begins at 1 + P + 10 + 1 + WIN + 21, P = 10 + 1 + WIN + 21 + WIN.
        r = 1 + (10 + 1 + WIN + 21 + WIN) + 10 + 1 + WIN + 21 + 10;
        start_plan[0] = 1'b1;
        reset_plan[r] = 1'b1;
        start_plan[r + 5] = 1'b1;
        model_run(0, 10, 1'b0, 21);
        truncate(r);
        model_run(r + 5, 10, 1'b0, 21);
        simulate(n, 10, 1'b0, 1'b0);
        for (int s = 0; s < NSIG; s++) begin
            dk = first_diff(s, n);
            tests_run++;
            if (dk != -1) begin
                tests_failed++;
                $display("FAIL midreset_%s cycle %0d: got %0d expected %0d", sig_name(s), dk, act_tr[s][dk], exp_tr[s][dk]);
            end
        end
        tests_run++;
        if (act_tr[4][r] != 1 || act_tr[5][r] != 1 || act_tr[4][r + 1] != 0 || act_tr[6][r + 1] != 0) begin
            tests_failed++;
            $display("FAIL midreset_edge: got mac=%0d key=%0d then mac=%0d busy=%0d expected 1 1 0 0",
                     act_tr[4][r], act_tr[5][r], act_tr[4][r + 1], act_tr[6][r + 1]);
        end
        $display("[TB] test_reset_mid_mac: reset at cycle %0d, restart at %0d", r, r + 5);
    endtask

    task automatic test_ntt_level();
        int n;
        int dk;
        int mac_first;
        n = 330;
        apply_reset();
        clear_plans();
        clear_expect();
        for (int i = 0; i < NTT_N; i++) ntt_off[i] = 1;
        start_plan[0] = 1'b1;
        model_run(0, 10, 1'b0, 2);
        simulate(n, 10, 1'b0, 1'b1);
        for (int s = 0; s < NSIG; s++) begin
            dk = first_diff(s, n);
            tests_run++;
            if (dk != -1) begin
                tests_failed++;
                $display("FAIL level_%s cycle %0d: got %0d expected %0d", sig_name(s), dk, act_tr[s][dk], exp_tr[s][dk]);
            end
        end
        mac_first = first_high(4, n);
        tests_run++;
        if (mac_first != 1 + 10 + 1 + WIN + 2) begin
            tests_failed++;
            $display("FAIL level_mac_rise: got cycle %0d expected %0d", mac_first, 1 + 10 + 1 + WIN + 2);
        end
        $display("[TB] test_ntt_level: ntt_done held high, first mac_en cycle %0d", mac_first);
    endtask

    task automatic test_random();
        int n;
        int dk;
        int s0;
        int dly;
        int lat;
        for (int run = 0; run < 4; run++) begin
            apply_reset();
            clear_plans();
            clear_expect();
            s0 = int'($urandom_range(0, 4));
            dly = int'($urandom_range(1, 20));
            lat = 0;
            for (int i = 0; i < NTT_N; i++) begin
                ntt_off[i] = int'($urandom_range(1, 30));
                if (ntt_off[i] + 1 > lat) lat = ntt_off[i] + 1;
            end
            n = s0 + 1 + NUM_ITER * (dly + 1 + WIN + lat + WIN) + 10;
            start_plan[s0] = 1'b1;
            model_run(s0, dly, 1'b0, lat);
            simulate(n, dly, 1'b0, 1'b0);
            for (int s = 0; s < NSIG; s++) begin
                dk = first_diff(s, n);
                tests_run++;
                if (dk != -1) begin
                    tests_failed++;
                    $display("FAIL random%0d_%s cycle %0d: got %0d expected %0d", run, sig_name(s), dk, act_tr[s][dk], exp_tr[s][dk]);
                end
            end
            $display("[TB] test_random %0d: start=%0d intt_delay=%0d offsets=%0d/%0d/%0d/%0d",
                     run, s0, dly, ntt_off[0], ntt_off[1], ntt_off[2], ntt_off[3]);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.intt_done = 1'b0;
        bus.ntt_done = '0;
        test_reset();
        test_basic();
        test_staggered();
        test_start_ignored();
        test_timeout();
        test_reset_mid_mac();
        test_ntt_level();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
